// File: rtl/fu_div_iter_pkg.sv
// Shared encodings and constants for the iterative RV32M divide unit (fu_div_iter).
package fu_div_iter_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 5;

  // funct3[1:0]: bit 0 selects unsigned, bit 1 selects remainder
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_t;

  localparam logic [XLEN_DEF-1:0] ALL_ONES = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] INT_MIN  = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/fu_div_iter_if.sv
// Issue/completion interface between the control unit (master) and the divide FU (slave).
interface fu_div_iter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  // Handshake: EN is taken on a rising edge only while busy==0 and kill==0;
  // the issuer must not present EN while busy==1 (it is dropped, not queued).
  // done is a one-cycle pulse, and res/rd_out hold their value until the next completion.
  logic             EN;
  logic [1:0]       op;
  logic [XLEN-1:0]  A;
  logic [XLEN-1:0]  B;
  logic [TAG_W-1:0] rd_in;
  logic             kill;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  res;
  logic [TAG_W-1:0] rd_out;

  modport master (output EN, op, A, B, rd_in, kill,
                  input  busy, done, res, rd_out);
  modport slave  (input  EN, op, A, B, rd_in, kill,
                  output busy, done, res, rd_out);
endinterface

// File: rtl/fu_div_iter_div_restore_step.sv
// One combinational radix-2 restoring division step: shift {rem,quo} left, trial-subtract divisor.
module div_restore_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0]   part;
  logic            ge;
  logic [XLEN-1:0] diff;

  always_comb begin
    part = {rem_in, quo_in[XLEN-1]};
    ge   = (part >= {1'b0, divisor});
    // When ge holds the true difference is below divisor, so XLEN bits suffice
    diff    = part[XLEN-1:0] - divisor;
    rem_out = ge ? diff : part[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], ge};
  end
endmodule

// File: rtl/fu_div_iter.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit. Optional FU_DIV_EARLY_OUT_EN skips the
// iterations for divide-by-zero and signed overflow; results are identical either way.
module fu_div_iter
  import fu_div_iter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  fu_div_iter_if.slave io,
  output div_state_t   state_dbg
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0]  ONES_X    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  INT_MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN-1);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, a_raw_q;
  logic             neg_quo_q, neg_rem_q, div0_q, ovf_q, is_rem_q;
  logic [TAG_W-1:0] tag_q;
  logic             busy_q, done_q;
  logic [XLEN-1:0]  res_q;
  logic [TAG_W-1:0] rd_out_q;

  logic             signed_op, a_neg, b_neg, in_div0, in_ovf;
  logic [XLEN-1:0]  a_abs, b_abs;
  logic [XLEN-1:0]  rem_nxt, quo_nxt;
  logic [XLEN-1:0]  quo_fix, rem_fix, res_sel;

  always_comb begin
    signed_op = ~io.op[0];
    a_neg     = signed_op & io.A[XLEN-1];
    b_neg     = signed_op & io.B[XLEN-1];
    a_abs     = a_neg ? (~io.A + 1'b1) : io.A;
    b_abs     = b_neg ? (~io.B + 1'b1) : io.B;
    in_div0   = (io.B == '0);
    in_ovf    = signed_op & (io.A == INT_MIN_X) & (io.B == ONES_X);
  end

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // Special cases override the magnitude result so the early-out path can reuse FIX
  always_comb begin
    quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    if (div0_q) begin
      quo_fix = ONES_X;
      rem_fix = a_raw_q;
    end else if (ovf_q) begin
      quo_fix = INT_MIN_X;
      rem_fix = '0;
    end
    res_sel = is_rem_q ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      a_raw_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      is_rem_q  <= 1'b0;
      tag_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
      rd_out_q  <= '0;
    end else if (io.kill) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (io.EN) begin
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvsr_q    <= b_abs;
            a_raw_q   <= io.A;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= in_div0;
            ovf_q     <= in_ovf;
            is_rem_q  <= io.op[1];
            tag_q     <= io.rd_in;
            count     <= '0;
            busy_q    <= 1'b1;
`ifdef FU_DIV_EARLY_OUT_EN
            state     <= (in_div0 | in_ovf) ? ST_FIX : ST_CALC;
`else
            state     <= ST_CALC;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          count <= count + 1'b1;
          if (count == CNT_LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          res_q    <= res_sel;
          rd_out_q <= tag_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.res    = res_q;
  assign io.rd_out = rd_out_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_fu_div_iter.sv
// Scoreboard bench for fu_div_iter: expected {rd,res} and latency queued at issue, checked on done.
module tb_fu_div_iter;
  import fu_div_iter_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LAT   = XLEN + 2;
`ifdef FU_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  div_state_t state_dbg;
  int         cyc;
  int         n_checks;
  int         n_fail;
  logic [XLEN+TAG_W-1:0] exp_q[$];
  int         lat_q[$];
  int         acc_q[$];
  logic [XLEN-1:0] last_res;

  fu_div_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) dif ();

  fu_div_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (dif),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic ovf;
    ovf = (a == INT_MIN) && (b == ALL_ONES);
    case (op)
      2'b00:   model = (b == 0) ? ALL_ONES : ovf ? INT_MIN : XLEN'($signed(a) / $signed(b));
      2'b01:   model = (b == 0) ? ALL_ONES : a / b;
      2'b10:   model = (b == 0) ? a : ovf ? '0 : XLEN'($signed(a) % $signed(b));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    is_special = (b == 0) || (!op[0] && a == INT_MIN && b == ALL_ONES);
  endfunction

  // driver: waits for busy==0, presents EN for one edge, optionally queues the expectation
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] rd, input bit want_done, output int acc_cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (dif.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (dif.busy) check("issue_timeout", 1, 0);
    dif.EN = 1'b1; dif.op = op; dif.A = a; dif.B = b; dif.rd_in = rd;
    @(posedge clk);
    #1;
    dif.EN = 1'b0;
    acc_cyc = cyc;
    if (want_done) begin
      exp_q.push_back({rd, model(op, a, b)});
      lat_q.push_back((EARLY && is_special(op, a, b)) ? 2 : LAT);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((dif.busy || exp_q.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("wait_idle_timeout", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (dif.done) begin
      if (exp_q.size() == 0) begin
        check("extra_done", {dif.rd_out, dif.res}, 0);
      end else begin
        logic [XLEN+TAG_W-1:0] e;
        int lat, acc;
        e   = exp_q.pop_front();
        lat = lat_q.pop_front();
        acc = acc_q.pop_front();
        check("res", dif.res, e[XLEN-1:0]);
        check("rd_out", dif.rd_out, e[XLEN+TAG_W-1:XLEN]);
        check("latency", cyc - acc + 1, lat);
        last_res = e[XLEN-1:0];
      end
    end
  end

  initial begin
    int a0, a1, bc;
    logic [TAG_W-1:0] last_rd;
    n_checks = 0; n_fail = 0; cyc = 0; last_res = '0;
    rst_n = 1'b0;
    dif.EN = 1'b0; dif.op = 2'b00; dif.A = '0; dif.B = '0; dif.rd_in = '0; dif.kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", dif.busy, 0);
    check("rst_done", dif.done, 0);
    check("rst_res", dif.res, 0);
    check("rst_rd", dif.rd_out, 0);
    check("rst_state", state_dbg, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // DIVU 100/7 with busy-length measurement
    issue(2'b01, 32'd100, 32'd7, 5'd1, 1'b1, a0);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dif.busy) bc++;
      else break;
    end
    check("busy_cycles", bc, XLEN + 1);
    wait_idle();

    issue(2'b11, 32'd100, 32'd7, 5'd2, 1'b1, a0);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1, a0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, a0);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 1'b1, a0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, a0);
    issue(2'b01, 32'd5, 32'd0, 5'd7, 1'b1, a0);
    issue(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd8, 1'b1, a0);
    issue(2'b00, 32'hFFFF_FFFB, 32'd0, 5'd10, 1'b1, a0);
    issue(2'b11, 32'd1234, 32'd0, 5'd11, 1'b1, a0);
    wait_idle();

    // back-to-back: second EN presented in the DONE cycle
    issue(2'b01, 32'd1000, 32'd10, 5'd4, 1'b1, a0);
    issue(2'b00, 32'hFFFF_FC18, 32'd33, 5'd9, 1'b1, a1);
    check("b2b_gap", a1 - a0, LAT);
    wait_idle();

    // EN while busy is dropped
    issue(2'b00, 32'd12345, 32'hFFFF_FFEF, 5'd6, 1'b1, a0);
    repeat (5) @(negedge clk);
    dif.EN = 1'b1; dif.op = 2'b01; dif.A = 32'd9; dif.B = 32'd2; dif.rd_in = 5'd3;
    repeat (3) @(negedge clk);
    dif.EN = 1'b0;
    check("ignored_en_state", state_dbg, ST_CALC);
    wait_idle();

    // kill at count==10
    last_rd = 5'd6;
    issue(2'b01, 32'd77, 32'd3, 5'd12, 1'b0, a0);
    repeat (11) @(negedge clk);
    dif.kill = 1'b1;
    @(posedge clk);
    #1;
    dif.kill = 1'b0;
    check("kill_busy", dif.busy, 0);
    check("kill_done", dif.done, 0);
    check("kill_res_hold", dif.res, last_res);
    check("kill_rd_hold", dif.rd_out, last_rd);
    check("kill_state", state_dbg, ST_IDLE);
    repeat (40) @(negedge clk);
    issue(2'b11, 32'd77, 32'd3, 5'd13, 1'b1, a0);
    wait_idle();

    // async reset mid-CALC
    issue(2'b01, 32'd999, 32'd4, 5'd14, 1'b0, a0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", dif.busy, 0);
    check("arst_done", dif.done, 0);
    check("arst_res", dif.res, 0);
    check("arst_rd", dif.rd_out, 0);
    check("arst_state", state_dbg, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b10, 32'd999, 32'd4, 5'd15, 1'b1, a0);
    wait_idle();

    // random operations
    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [XLEN-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = 32'($urandom_range(0, 1));
        default: b = $urandom();
      endcase
      issue(op, a, b, 5'($urandom_range(0, 31)), 1'b1, a0);
    end
    wait_idle();

    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
